// File: rtl/sft_deser_rx_pkg.sv
// Shared types and constants for the sft_deser_rx serial frame receiver.
package sft_rx_pkg;

  localparam int unsigned DEF_DATA_W = 9;
  localparam int unsigned DEF_OVS    = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } rx_state_e;

  // Width of the oversampling tick counter (must hold OVS-1).
  function automatic int unsigned tick_cnt_w(input int unsigned ovs);
    return (ovs <= 2) ? 1 : $clog2(ovs);
  endfunction

endpackage

// File: rtl/sft_deser_rx_if.sv
// Valid/ready word interface between the receiver (master) and its consumer (slave).
interface sft_deser_rx_if #(
  parameter int unsigned DATA_W = sft_rx_pkg::DEF_DATA_W
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/sft_deser_rx_shifter.sv
// Receive shift register: clears on frame start, shifts one sampled bit per enable.
module sft_rx_shifter #(
  parameter int unsigned DATA_W = sft_rx_pkg::DEF_DATA_W
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              msb_first,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clr) begin
      data <= '0;
    end else if (shift_en) begin
      if (msb_first) data <= {data[DATA_W-2:0], bit_in};
      else           data <= {bit_in, data[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/sft_deser_rx.sv
// Oversampling serial frame receiver with valid/ready output holding register.
// Optional even-parity bit enabled by defining SFT_RX_PARITY_EN.
module sft_deser_rx
  import sft_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OVS    = DEF_OVS
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic                  rx_serial,
  input  logic                  msb_first,
  sft_deser_rx_if.master        rx,
  output logic                  frm_err,
  output logic                  par_err,
  output logic                  ovr_err,
  output logic                  busy
);

  localparam int unsigned CNT_W = tick_cnt_w(OVS);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  rx_state_e         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic              dir_q, dir_n;
  logic              rx_meta, rx_s;
  logic              shift_c, clr_c, commit_c, frm_c;
  logic [DATA_W-1:0] shift_q;
`ifdef SFT_RX_PARITY_EN
  logic              par_acc, par_acc_n, par_bad, par_bad_n, perr_c;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      dir_q   <= 1'b0;
`ifdef SFT_RX_PARITY_EN
      par_acc <= 1'b0;
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      dir_q   <= dir_n;
`ifdef SFT_RX_PARITY_EN
      par_acc <= par_acc_n;
      par_bad <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    dir_n     = dir_q;
    shift_c   = 1'b0;
    clr_c     = 1'b0;
    commit_c  = 1'b0;
    frm_c     = 1'b0;
`ifdef SFT_RX_PARITY_EN
    par_acc_n = par_acc;
    par_bad_n = par_bad;
    perr_c    = 1'b0;
`endif
    if (baud_tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt_n = '0;
            if (!rx_s) begin
              state_n   = DATA;
              dir_n     = msb_first;
              bit_cnt_n = '0;
              clr_c     = 1'b1;
`ifdef SFT_RX_PARITY_EN
              par_acc_n = 1'b0;
              par_bad_n = 1'b0;
`endif
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt_n   = '0;
            shift_c = 1'b1;
`ifdef SFT_RX_PARITY_EN
            par_acc_n = par_acc ^ rx_s;
`endif
            if (bit_cnt == LAST_BIT) begin
`ifdef SFT_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        PARITY: begin
`ifdef SFT_RX_PARITY_EN
          if (cnt == FULL_M1) begin
            cnt_n     = '0;
            par_bad_n = par_acc ^ rx_s;
            state_n   = STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
`else
          state_n = STOP;
`endif
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt_n = '0;
            if (rx_s) begin
              state_n = IDLE;
`ifdef SFT_RX_PARITY_EN
              if (par_bad) perr_c   = 1'b1;
              else         commit_c = 1'b1;
`else
              commit_c = 1'b1;
`endif
            end else begin
              frm_c   = 1'b1;
              state_n = RECOVER;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RECOVER: begin
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  sft_rx_shifter #(.DATA_W(DATA_W)) u_shifter (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .clr       (clr_c),
    .shift_en  (shift_c),
    .msb_first (dir_q),
    .bit_in    (rx_s),
    .data      (shift_q)
  );

  // Holding register: a commit into a full, unaccepted register is dropped as overrun.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx.rx_data  <= '0;
      rx.rx_valid <= 1'b0;
      frm_err     <= 1'b0;
      ovr_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frm_err <= frm_c;
      ovr_err <= 1'b0;
      busy    <= (state_n != IDLE);
      if (commit_c) begin
        if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_data  <= shift_q;
          rx.rx_valid <= 1'b1;
        end else begin
          ovr_err <= 1'b1;
        end
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

`ifdef SFT_RX_PARITY_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= perr_c;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sft_deser_rx.sv
// Self-checking bench for sft_deser_rx: directed frames plus random frames vs a frame-level model.
module tb_sft_deser_rx;
  import sft_rx_pkg::*;

  localparam int unsigned DW  = 9;
  localparam int unsigned OVS = 16;
`ifdef SFT_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic sys_clk   = 1'b0;
  logic rst_n;
  logic baud_tick = 1'b0;
  logic rx_serial = 1'b1;
  logic msb_first = 1'b0;
  logic frm_err, par_err, ovr_err, busy;

  sft_deser_rx_if #(.DATA_W(DW)) rx_if ();

  sft_deser_rx #(.DATA_W(DW), .OVS(OVS)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .rx_serial (rx_serial),
    .msb_first (msb_first),
    .rx        (rx_if.master),
    .frm_err   (frm_err),
    .par_err   (par_err),
    .ovr_err   (ovr_err),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // One baud tick every third clock, driven away from the sampling edge.
  initial begin
    forever begin
      repeat (2) @(negedge sys_clk);
      baud_tick = 1'b1;
      @(negedge sys_clk);
      baud_tick = 1'b0;
    end
  end

  int tests = 0;
  int fails = 0;

  // Observed activity on the DUT outputs.
  int           frm_cnt = 0, par_cnt = 0, ovr_cnt = 0;
  logic [DW-1:0] got_q[$];
  logic         prev_valid = 1'b0;
  logic         rdy_edge;

  always @(posedge sys_clk) begin
    rdy_edge = rx_if.rx_ready;
    #1;
    if (rx_if.rx_valid === 1'b1 && (prev_valid !== 1'b1 || rdy_edge === 1'b1))
      got_q.push_back(rx_if.rx_data);
    if (frm_err === 1'b1) frm_cnt++;
    if (par_err === 1'b1) par_cnt++;
    if (ovr_err === 1'b1) ovr_cnt++;
    prev_valid = rx_if.rx_valid;
  end

  // Frame-level reference: what a consumer should see for each frame sent.
  logic [DW-1:0] exp_q[$];
  int           exp_frm = 0, exp_par = 0, exp_ovr = 0;
  bit           hold_full = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      while (baud_tick !== 1'b1) @(posedge sys_clk);
    end
    @(negedge sys_clk);
  endtask

  task automatic model_frame(input logic [DW-1:0] w, input bit stop_ok, input bit par_ok);
    if (!stop_ok)                        exp_frm++;
    else if (!par_ok)                    exp_par++;
    else if (hold_full && !rx_if.rx_ready) exp_ovr++;
    else begin
      exp_q.push_back(w);
      hold_full = !rx_if.rx_ready;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input bit msb, input bit par_flip,
                            input logic stop_val);
    logic bits[$];
    msb_first = msb;
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) bits.push_back(msb ? w[DW-1-i] : w[i]);
    if (PAR) bits.push_back((^w) ^ par_flip);
    bits.push_back(stop_val);
    foreach (bits[i]) begin
      rx_serial = bits[i];
      wait_ticks(OVS);
    end
    model_frame(w, stop_val === 1'b1, !(PAR && par_flip));
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_frm"}, frm_cnt, exp_frm);
    check({tag, "_par"}, par_cnt, exp_par);
    check({tag, "_ovr"}, ovr_cnt, exp_ovr);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #400000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    rx_if.rx_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    check("rst_valid", rx_if.rx_valid, 0);
    check("rst_data", 32'(rx_if.rx_data), 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {frm_err, par_err, ovr_err}, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    wait_ticks(4);

    // LSB-first word, consumer always ready.
    rx_if.rx_ready = 1'b1;
    send_frame(9'h1A5, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    check("lsb_valid_after", rx_if.rx_valid, 0);
    check("lsb_busy", busy, 0);
    compare_all("lsb_1a5");

    // Two MSB-first frames back-to-back with no consumer: second overruns.
    rx_if.rx_ready = 1'b0;
    send_frame(9'h0F3, 1'b1, 1'b0, 1'b1);
    send_frame(9'h10C, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);
    check("ovr_held_data", 32'(rx_if.rx_data), 32'h0F3);
    check("ovr_held_valid", rx_if.rx_valid, 1);
    check("ovr_busy", busy, 0);
    rx_if.rx_ready = 1'b1;
    hold_full = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("ovr_drained", rx_if.rx_valid, 0);
    compare_all("ovr");

    // Short glitch: false start.
    rx_serial = 1'b0;
    wait_ticks(3);
    rx_serial = 1'b1;
    wait_ticks(20);
    check("glitch_busy", busy, 0);
    check("glitch_valid", rx_if.rx_valid, 0);
    compare_all("glitch");

    // Stop bit low followed by a long break, then recovery.
    send_frame(9'h055, 1'b0, 1'b0, 1'b0);
    wait_ticks(40);
    check("break_busy", busy, 1);
    check("break_valid", rx_if.rx_valid, 0);
    check("break_frm", frm_cnt, 1);
    rx_serial = 1'b1;
    wait_ticks(4);
    check("recover_busy", busy, 0);
    send_frame(9'h001, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    compare_all("break");

    // Flipped parity bit (only distinguishable when parity is built in).
    send_frame(9'h0FF, 1'b0, 1'b1, 1'b1);
    wait_ticks(4);
    check("par_valid", rx_if.rx_valid, 0);
    compare_all("parity");

    // Reset in the middle of the data bits.
    send_frame(9'h0AA, 1'b1, 1'b0, 1'b1);
    wait_ticks(2);
    w = 9'h155;
    rx_serial = 1'b0;
    wait_ticks(OVS);
    for (int i = 0; i < 3; i++) begin
      rx_serial = w[i];
      wait_ticks(OVS);
    end
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(rx_if.rx_data), 0);
    check("mid_rst_valid", rx_if.rx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_errs", {frm_err, par_err, ovr_err}, 0);
    rx_serial = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    wait_ticks(4);
    send_frame(9'h0AA, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    compare_all("rst_mid");

    // Random words and bit orders, with and without idle gaps.
    for (int n = 0; n < 10; n++) begin
      int gap;
      w = DW'($urandom_range(0, (1 << DW) - 1));
      send_frame(w, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      gap = $urandom_range(0, 3);
      if (gap != 0) wait_ticks(gap * 7);
    end
    wait_ticks(4);
    compare_all("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sft_deser_rx.md
# sft_deser_rx

Serial frame receiver: the inbound counterpart of the 9-bit load/shift serializer. It oversamples a serial line, detects the start bit, shifts DATA_W data bits into an internal shift register in the selected bit order, optionally checks parity, and validates the stop bit. Each good frame is presented as a parallel word on a valid/ready interface. It sits between the pad-side serial input and the FSM or datapath that consumes received words.

## Interface
- DATA_W, 9: data bits per frame.
- OVS, 16: baud_tick pulses per bit period; even, ≥4.
- sys_clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- baud_tick  in  1  one-cycle strobe at OVS × bit rate.
- rx_serial  in  1  asynchronous serial line; idles high.
- msb_first  in  1  bit order, sampled at start-bit confirm: 1 = MSB first (left shift), 0 = LSB first (right shift).
- rx_data  out  DATA_W  received word; stable while rx_valid=1.
- rx_valid  out  1  word available.
- rx_ready  in  1  consumer accepts; a transfer occurs when rx_valid & rx_ready.
- frm_err  out  1  one-cycle pulse: stop bit sampled low.
- par_err  out  1  one-cycle pulse: parity mismatch (tied 0 without the macro).
- ovr_err  out  1  one-cycle pulse: good frame dropped because the holding register is full.
- busy  out  1  FSM not in IDLE.

## Operation
- rx_serial passes through a 2-flop synchronizer; both flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP, RECOVER. All state, counters, and samples advance only on baud_tick.
- IDLE: synchronized rx=0 on a tick -> START; tick counter = 0.
- START: at tick OVS/2 (mid-bit), rx=0 confirms the start bit -> DATA and latches msb_first. rx=1 is a false start -> IDLE with no error.
- DATA: samples every OVS ticks. MSB-first: shift left, new bit into bit 0. LSB-first: shift right, new bit into bit DATA_W-1. After DATA_W bits -> PARITY if enabled, else STOP.
- PARITY: samples one bit after OVS ticks -> STOP.
- STOP: samples after OVS ticks.
  - rx=1 and parity OK: commit the word -> IDLE.
  - rx=1 and parity bad: pulse par_err, discard the word -> IDLE.
  - rx=0: pulse frm_err, discard the word -> RECOVER. If parity is also bad, only frm_err pulses.
- RECOVER: waits for rx=1 on a tick -> IDLE. A break condition therefore never retriggers.
- Commit:
  - If rx_valid=0, or rx_valid & rx_ready in the same cycle: load rx_data, set rx_valid.
  - Otherwise: keep the old rx_data, pulse ovr_err, drop the new word.
- rx_valid clears on transfer unless a commit happens in the same cycle, in which case it stays 1 with the new data.
- Reset values: rx_data=0, rx_valid=0, frm_err=0, par_err=0, ovr_err=0, busy=0, state=IDLE, shift register=0.

## Timing
- Synchronizer latency: 2 sys_clk.
- Start-bit confirm: OVS/2 ticks after detection. Each subsequent bit is sampled OVS ticks after the previous sample.
- rx_valid rises on the sys_clk edge after the tick that samples the stop bit. Error pulses occur on that same edge.
- rx_valid does not depend combinationally on rx_ready.
- rx_ready is ignored while rx_valid=0.
- rst_n asserted mid-frame: immediate return to reset values. The partial frame is lost and no error pulses.
- The receiver keeps running while rx_valid=1. Back-to-back frames with a single stop bit are received without loss if the consumer accepts within one frame time.

## Configuration
- SFT_RX_PARITY_EN defined: frame = start + DATA_W data + 1 even-parity bit + stop. Parity is computed over the data bits, and a mismatch pulses par_err.
- Undefined: frame = start + DATA_W data + stop. The PARITY state is unreachable and par_err is constant 0.

## Structure
- Shared package sft_rx_pkg:
  - state enum (IDLE..RECOVER);
  - default OVS and DATA_W constants;
  - tick-counter width function clog2(OVS).
- Sub-module sft_rx_shifter: DATA_W-bit shift register with clear, shift-in bit, direction select, and shift enable. This is the receive-side mirror of the serializer's shift register.
- The FSM, counters, parity accumulator, and holding register live in sft_deser_rx.

## Test plan
- LSB-first 9'h1A5, parity enabled, rx_ready=1 -> one rx_valid pulse, rx_data=9'h1A5, no errors.
- MSB-first 9'h0F3, then 9'h10C back-to-back with rx_ready=0 -> rx_data=9'h0F3 held, ovr_err pulses once, busy returns to 0.
- rx low for only 3 ticks (glitch) -> false start, no rx_valid, no errors, FSM back in IDLE.
- Stop bit forced low, then line held low for 40 ticks -> single frm_err pulse, no rx_valid, RECOVER held until rx=1, next frame 9'h001 received correctly.
- Parity bit flipped on 9'h0FF -> par_err pulse, rx_valid stays 0. With the macro undefined, the same stream minus the parity bit gives rx_data=9'h0FF.
- rst_n pulsed low mid-DATA of 9'h155 -> all outputs 0 immediately, no error pulse, next full frame 9'h0AA received correctly.
